// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed 7-segment bus, filters scan glitches and decodes each digit back to BCD.
// Optional macro SEG7_HEX_EN: the A..F segment patterns also decode as legal hex digits.
module seg7_scan_decoder #(
  parameter int NDIG       = 4,
  parameter int STABLE     = 3,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        seg,
  input  logic [NDIG-1:0]   dig_sel,
  input  logic              sample_en,
  input  logic              err_clr,
  output logic [4*NDIG-1:0] bcd_out,
  output logic [NDIG-1:0]   dp_out,
  output logic [NDIG-1:0]   digit_valid,
  output logic              frame_valid,
  output logic              err
);

  localparam int         SW  = NDIG + 8;
  localparam logic [3:0] STB = 4'(STABLE);

  typedef enum logic {COLLECT, EMIT} state_e;

  // {legal, nibble}; illegal patterns report nibble F
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h3F: r = 5'h10;
      7'h06: r = 5'h11;
      7'h5B: r = 5'h12;
      7'h4F: r = 5'h13;
      7'h66: r = 5'h14;
      7'h6D: r = 5'h15;
      7'h7D: r = 5'h16;
      7'h07: r = 5'h17;
      7'h7F: r = 5'h18;
      7'h6F: r = 5'h19;
`ifdef SEG7_HEX_EN
      7'h77: r = 5'h1A;
      7'h7C: r = 5'h1B;
      7'h39: r = 5'h1C;
      7'h5E: r = 5'h1D;
      7'h79: r = 5'h1E;
      7'h71: r = 5'h1F;
`endif
      default: r = 5'h0F;
    endcase
    return r;
  endfunction

  logic [7:0]        seg_ah;
  logic [SW-1:0]     smp;
  logic              blank, multi, accept, legal;
  logic [4:0]        dec;
  logic [NDIG-1:0]   acc_mask;

  logic [3:0]        cnt_q, cnt_d;
  logic [SW-1:0]     hist_q, hist_d;
  logic [4*NDIG-1:0] bcd_q, bcd_d;
  logic [NDIG-1:0]   dp_q, dp_d, dv_q, dv_d, seen_q, seen_d;
  logic              err_q, err_d;
  state_e            state_q, state_d;

  assign seg_ah   = ACTIVE_LOW ? ~seg : seg;
  assign smp      = {dig_sel, seg_ah};
  assign blank    = (dig_sel == '0);
  assign multi    = ((dig_sel & (dig_sel - NDIG'(1))) != '0);
  assign dec      = decode(seg_ah[6:0]);
  assign legal    = dec[4];
  assign acc_mask = accept ? dig_sel : '0;

  // Stability filter: accept fires only on the sample where the run length hits STABLE
  always_comb begin
    cnt_d  = cnt_q;
    hist_d = hist_q;
    accept = 1'b0;
    if (sample_en) begin
      if (blank || multi) begin
        cnt_d  = '0;
        hist_d = smp;
      end else if (smp == hist_q) begin
        if (cnt_q < STB) begin
          cnt_d  = cnt_q + 4'd1;
          accept = (cnt_q + 4'd1 == STB);
        end
      end else begin
        cnt_d  = 4'd1;
        hist_d = smp;
        accept = (STB == 4'd1);
      end
    end
  end

  always_comb begin
    bcd_d = bcd_q;
    dp_d  = dp_q;
    dv_d  = dv_q;
    for (int i = 0; i < NDIG; i++) begin
      if (acc_mask[i]) begin
        bcd_d[4*i +: 4] = dec[3:0];
        dp_d[i]         = seg_ah[7];
        dv_d[i]         = legal;
      end
    end
    err_d = (err_q & ~err_clr) | (sample_en & multi) | (accept & ~legal);
  end

  // EMIT restarts the mask from this cycle's accept so it is not lost
  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    case (state_q)
      COLLECT: begin
        seen_d = seen_q | acc_mask;
        if (&seen_d) state_d = EMIT;
      end
      EMIT: begin
        seen_d  = acc_mask;
        state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      hist_q  <= '0;
      bcd_q   <= '1;
      dp_q    <= '0;
      dv_q    <= '0;
      seen_q  <= '0;
      err_q   <= 1'b0;
      state_q <= COLLECT;
    end else begin
      cnt_q   <= cnt_d;
      hist_q  <= hist_d;
      bcd_q   <= bcd_d;
      dp_q    <= dp_d;
      dv_q    <= dv_d;
      seen_q  <= seen_d;
      err_q   <= err_d;
      state_q <= state_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign dp_out      = dp_q;
  assign digit_valid = dv_q;
  assign err         = err_q;
  assign frame_valid = (state_q == EMIT);

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder (NDIG=4, STABLE=3, active-low bus).
module tb_seg7_scan_decoder;
  localparam int NDIG   = 4;
  localparam int STABLE = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  seg;
  logic [3:0]  dig_sel;
  logic        sample_en, err_clr;
  logic [15:0] bcd_out;
  logic [3:0]  dp_out, digit_valid;
  logic        frame_valid, err;

  seg7_scan_decoder #(.NDIG(NDIG), .STABLE(STABLE), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .dig_sel(dig_sel), .sample_en(sample_en),
    .err_clr(err_clr), .bcd_out(bcd_out), .dp_out(dp_out), .digit_valid(digit_valid),
    .frame_valid(frame_valid), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [6:0] PAT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: what the outputs should show after each clock
  logic [15:0] m_bcd;
  logic [3:0]  m_dp, m_dv, m_seen;
  logic        m_err, m_fv;
  logic [11:0] m_prev;
  int          m_run;

  function automatic int lookup(input logic [6:0] p);
    int lim = 10;
`ifdef SEG7_HEX_EN
    lim = 16;
`endif
    for (int i = 0; i < lim; i++) if (PAT[i] == p) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_bcd = 16'hFFFF; m_dp = '0; m_dv = '0; m_seen = '0;
    m_err = 1'b0; m_fv = 1'b0; m_prev = '0; m_run = 0;
  endtask

  task automatic model_clock(input logic [3:0] sel, input logic [7:0] s, input logic en, input logic clr);
    logic       acc, newerr;
    logic [11:0] cur;
    int         d, idx, ones;
    acc = 1'b0; newerr = 1'b0; cur = {sel, s}; idx = 0;
    ones = $countones(sel);
    if (en) begin
      if (ones != 1) begin
        m_run = 0; m_prev = cur;
        if (ones > 1) newerr = 1'b1;
      end else if (cur == m_prev) begin
        m_run++;
        acc = (m_run == STABLE);
      end else begin
        m_prev = cur; m_run = 1;
        acc = (STABLE == 1);
      end
    end
    if (acc) begin
      for (int i = 0; i < NDIG; i++) if (sel[i]) idx = i;
      d = lookup(s[6:0]);
      m_dp[idx] = s[7];
      if (d >= 0) begin
        m_bcd[4*idx +: 4] = d[3:0]; m_dv[idx] = 1'b1;
      end else begin
        m_bcd[4*idx +: 4] = 4'hF; m_dv[idx] = 1'b0; newerr = 1'b1;
      end
      m_seen |= sel;
    end
    m_err = (m_err && !clr) || newerr;
    m_fv = 1'b0;
    if (m_seen == 4'hF) begin
      m_fv = 1'b1; m_seen = '0;
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    checks++;
    if (bcd_out !== m_bcd || dp_out !== m_dp || digit_valid !== m_dv ||
        frame_valid !== m_fv || err !== m_err) begin
      errors++;
      $display("FAIL %s: got bcd=%h dp=%b dv=%b fv=%b err=%b want bcd=%h dp=%b dv=%b fv=%b err=%b",
               name, bcd_out, dp_out, digit_valid, frame_valid, err,
               m_bcd, m_dp, m_dv, m_fv, m_err);
    end
  endtask

  // Drive one clock of inputs (seg given active-high), then compare against the model
  task automatic step(input logic [3:0] sel, input logic [7:0] s, input logic en, input logic clr);
    dig_sel = sel; seg = ~s; sample_en = en; err_clr = clr;
    @(posedge clk);
    model_clock(sel, s, en, clr);
    #1;
    check_model("model");
  endtask

  task automatic hold(input logic [3:0] sel, input logic [7:0] s, input int n);
    for (int k = 0; k < n; k++) step(sel, s, 1'b1, 1'b0);
  endtask

  typedef struct {
    logic [3:0]  sel;
    logic [7:0]  s;
    logic        en;
    logic [15:0] bcd;
    logic [3:0]  dv;
    logic        fv;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] sel, input logic [7:0] s, input logic en,
                              input logic [15:0] bcd, input logic [3:0] dv, input logic fv);
    vec_t v;
    v.sel = sel; v.s = s; v.en = en; v.bcd = bcd; v.dv = dv; v.fv = fv;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [15:0] snap;
    logic [3:0]  sel;
    logic [7:0]  s;
    int          n;

    tbl.push_back(mk(4'h1, 8'h06, 1'b1, 16'hFFFF, 4'h0, 1'b0));
    tbl.push_back(mk(4'h1, 8'h06, 1'b1, 16'hFFFF, 4'h0, 1'b0));
    tbl.push_back(mk(4'h1, 8'h06, 1'b1, 16'hFFF1, 4'h1, 1'b0));
    tbl.push_back(mk(4'h1, 8'h66, 1'b1, 16'hFFF1, 4'h1, 1'b0));
    tbl.push_back(mk(4'h1, 8'h66, 1'b1, 16'hFFF1, 4'h1, 1'b0));
    tbl.push_back(mk(4'h1, 8'h66, 1'b1, 16'hFFF4, 4'h1, 1'b0));
    tbl.push_back(mk(4'h2, 8'h6D, 1'b1, 16'hFFF4, 4'h1, 1'b0));
    tbl.push_back(mk(4'h2, 8'h6D, 1'b1, 16'hFFF4, 4'h1, 1'b0));
    tbl.push_back(mk(4'h2, 8'h6D, 1'b1, 16'hFF54, 4'h3, 1'b0));
    tbl.push_back(mk(4'h4, 8'h7D, 1'b1, 16'hFF54, 4'h3, 1'b0));
    tbl.push_back(mk(4'h4, 8'h7D, 1'b1, 16'hFF54, 4'h3, 1'b0));
    tbl.push_back(mk(4'h4, 8'h7D, 1'b1, 16'hF654, 4'h7, 1'b0));
    tbl.push_back(mk(4'h8, 8'h07, 1'b1, 16'hF654, 4'h7, 1'b0));
    tbl.push_back(mk(4'h8, 8'h07, 1'b1, 16'hF654, 4'h7, 1'b0));
    tbl.push_back(mk(4'h8, 8'h07, 1'b1, 16'h7654, 4'hF, 1'b1));
    tbl.push_back(mk(4'h8, 8'h07, 1'b0, 16'h7654, 4'hF, 1'b0));

    rst_n = 1'b0; dig_sel = '0; seg = 8'hFF; sample_en = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset bcd", bcd_out, 16'hFFFF);
    chk("reset flags", {8'h0, dp_out, digit_valid}, 16'h0);
    chk("reset fv/err", {14'h0, frame_valid, err}, 16'h0);
    @(negedge clk); rst_n = 1'b1;

    // Single digit, then a full scan frame
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].sel, tbl[i].s, tbl[i].en, 1'b0);
      chk("tbl bcd", bcd_out, tbl[i].bcd);
      chk("tbl dv", {12'h0, digit_valid}, {12'h0, tbl[i].dv});
      chk("tbl fv", {15'h0, frame_valid}, {15'h0, tbl[i].fv});
    end

    // Glitch on digit 1: only the final stable run of 0x5B lands
    begin
      logic [7:0] gl [6] = '{8'h5B, 8'h5B, 8'h4F, 8'h5B, 8'h5B, 8'h5B};
      for (int k = 0; k < 6; k++) begin
        step(4'h2, gl[k], 1'b1, 1'b0);
        chk("glitch nib1", {12'h0, bcd_out[7:4]}, (k == 5) ? 16'h2 : 16'h5);
      end
    end

    // Illegal pattern on digit 2, sticky err, clear, and set-wins-over-clear
    hold(4'h4, 8'h40, 3);
    chk("illegal nib2", {12'h0, bcd_out[11:8]}, 16'hF);
    chk("illegal dv2", {15'h0, digit_valid[2]}, 16'h0);
    chk("illegal err", {15'h0, err}, 16'h1);
    step(4'h4, 8'h40, 1'b0, 1'b0);
    step(4'h4, 8'h40, 1'b0, 1'b0);
    chk("err sticky", {15'h0, err}, 16'h1);
    step(4'h4, 8'h40, 1'b0, 1'b1);
    chk("err clr", {15'h0, err}, 16'h0);
    step(4'h4, 8'h00, 1'b1, 1'b1);
    step(4'h4, 8'h00, 1'b1, 1'b1);
    chk("err clr held", {15'h0, err}, 16'h0);
    step(4'h4, 8'h00, 1'b1, 1'b1);
    chk("err set wins", {15'h0, err}, 16'h1);

    // Multi-hot select, then blanking
    step(4'h0, 8'h00, 1'b0, 1'b1);
    snap = bcd_out;
    step(4'h3, 8'h3F, 1'b1, 1'b0);
    chk("multi err", {15'h0, err}, 16'h1);
    chk("multi bcd", bcd_out, snap);
    for (int k = 0; k < 5; k++) begin
      step(4'h0, 8'h3F, 1'b1, 1'b0);
      chk("blank fv", {15'h0, frame_valid}, 16'h0);
    end
    chk("blank bcd", bcd_out, snap);

    // Reset mid-frame after digits 0 and 1
    step(4'h0, 8'h00, 1'b0, 1'b1);
    hold(4'h1, 8'h7F, 3);
    hold(4'h2, 8'h6F, 3);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_model("async reset");
    chk("async reset bcd", bcd_out, 16'hFFFF);
    @(negedge clk); rst_n = 1'b1;
    hold(4'h1, 8'h06, 3);
    hold(4'h2, 8'h5B, 3);
    hold(4'h4, 8'h4F, 3);
    chk("partial frame fv", {15'h0, frame_valid}, 16'h0);
    hold(4'h8, 8'h3F, 3);
    chk("post-reset frame fv", {15'h0, frame_valid}, 16'h1);
    chk("post-reset bcd", bcd_out, 16'h0321);

    // Hex pattern A
    hold(4'h1, 8'h77, 3);
`ifdef SEG7_HEX_EN
    chk("hex nib0", {12'h0, bcd_out[3:0]}, 16'hA);
    chk("hex err", {15'h0, err}, 16'h0);
`else
    chk("hex nib0", {12'h0, bcd_out[3:0]}, 16'hF);
    chk("hex err", {15'h0, err}, 16'h1);
`endif

    // Randomized runs against the model
    for (int r = 0; r < 300; r++) begin
      n = $urandom_range(0, 9);
      if (n == 0)      sel = 4'h0;
      else if (n == 1) sel = 4'h3 << $urandom_range(0, 2);
      else             sel = 4'h1 << $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) s = 8'($urandom);
      else s = {1'($urandom), PAT[$urandom_range(0, 15)]};
      n = $urandom_range(1, 5);
      for (int h = 0; h < n; h++)
        step(sel, s, ($urandom_range(0, 4) != 0), ($urandom_range(0, 19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the BCD-to-7-segment display path.
- Samples a multiplexed 7-segment bus (segment lines plus one-hot digit select).
- Filters scan glitches and decodes each segment pattern back to a BCD nibble per digit.
- Flags illegal patterns and pulses when a full display frame has been captured.
- Used as a loopback checker beside the segment driver and as a capture block for external display buses.

Parameters:
- NDIG, 4, number of multiplexed digits (1..8).
- STABLE, 3, consecutive identical samples required before a pattern is accepted (1..15).
- ACTIVE_LOW, 1, 1 = segment and dp lines are active-low (common anode); 0 = active-high.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- seg  input  8  {dp,g,f,e,d,c,b,a}; polarity set by ACTIVE_LOW.
- dig_sel  input  NDIG  digit select, active-high, expected one-hot or all-zero (blank).
- sample_en  input  1  sample strobe; bus is evaluated only on clocks where it is high.
- err_clr  input  1  synchronous clear of err.
- bcd_out  output  4*NDIG  nibble i = decoded value of digit i; 4'hF when the pattern is invalid.
- dp_out  output  NDIG  decoded decimal point per digit.
- digit_valid  output  NDIG  bit i = last accepted pattern for digit i was legal.
- frame_valid  output  1  one-cycle pulse: every digit accepted at least once since the last pulse.
- err  output  1  sticky: illegal pattern or multi-hot dig_sel seen.

Behaviour:
- Reset (async, rst_n low):
  - bcd_out = all 4'hF.
  - dp_out = 0, digit_valid = 0, frame_valid = 0, err = 0.
  - Sample history cleared, stability counter = 0, seen mask = 0, FSM = COLLECT.
- Normalisation: when ACTIVE_LOW=1, seg is inverted internally; all decoding below is on active-high values.
- Legal patterns (active-high, bits g..a):
  - 0 = 0x3F, 1 = 0x06, 2 = 0x5B, 3 = 0x4F, 4 = 0x66.
  - 5 = 0x6D, 6 = 0x7D, 7 = 0x07, 8 = 0x7F, 9 = 0x6F.
  - Any other value is illegal.
- Stability filter, evaluated only when sample_en = 1:
  - If {dig_sel,seg} equals the previous sample, the counter increments, saturating at STABLE.
  - Otherwise the counter loads 1 and the history register updates.
  - Accept fires on the sample where the counter reaches STABLE, exactly once per stable run.
  - When STABLE = 1, every change is accepted on its first sample.
- Blanking: dig_sel = 0 resets the counter to 0 and never accepts.
- Multi-hot dig_sel:
  - Sets err, resets the counter, no accept.
  - Outputs are unchanged.
- Accept for digit i (registered on the same clock edge as the accepting sample, so visible one cycle after sample_en):
  - Legal pattern: bcd_out[4i+:4] = value, dp_out[i] = dp, digit_valid[i] = 1.
  - Illegal pattern: nibble = 4'hF, dp_out[i] = dp, digit_valid[i] = 0, err = 1.
  - seen[i] is set in both cases.
- FSM:
  - COLLECT: update seen on each accept. When seen (including the current accept) is all-ones, go to EMIT.
  - EMIT (one cycle): frame_valid = 1, seen cleared, return to COLLECT.
  - An accept arriving during EMIT is recorded into the freshly cleared mask and is not lost.
  - Re-accepting an already-seen digit within a frame updates its outputs but does not advance the frame.
- err_clr and a new error in the same cycle: err stays 1 (set wins).
- sample_en = 0: history, counter and outputs hold.
- Reset mid-run: all state returns to reset values immediately; the partial frame is discarded.

Optional Feature:
- Macro: SEG7_HEX_EN.
- Defined: additional legal patterns decode as hex digits.
  - A = 0x77, b = 0x7C, C = 0x39, d = 0x5E, E = 0x79, F = 0x71.
  - These set digit_valid and do not raise err.
  - 4'hF is then ambiguous; consumers must use digit_valid to tell a decoded F from an invalid pattern.
- Not defined: those patterns are illegal (nibble = 4'hF, err = 1).

Test Plan:
- Reset, then hold dig_sel=0001 and seg=~0x06 (ACTIVE_LOW=1) for 3 sample_en clocks:
  - bcd_out[3:0] = 1 and digit_valid[0] = 1 one cycle after the 3rd sample.
  - No update after the 1st or 2nd sample.
- Glitch: 2 samples of 0x5B, 1 sample of 0x4F, then 3 samples of 0x5B on digit 1:
  - Only the final run is accepted; nibble 1 = 2.
  - 0x4F is never accepted.
- Scan digits 0..3 with values 4,5,6,7, each held 3 samples:
  - frame_valid pulses exactly once, one cycle after digit 3 is accepted.
  - bcd_out = 16'h7654.
- Illegal pattern 0x40 on digit 2:
  - Nibble 2 = F, digit_valid[2] = 0, err = 1.
  - err holds until err_clr; with err_clr and a new error in the same cycle, err stays 1.
- dig_sel=0011:
  - err = 1, no output change.
  - dig_sel=0000 for 5 samples produces no accept and no frame_valid.
- Assert rst_n low in mid-frame after digits 0 and 1 are accepted:
  - Outputs return to reset values.
  - A following frame needs all 4 digits before frame_valid.
  - With SEG7_HEX_EN defined, pattern 0x77 decodes to nibble A with err = 0.
